// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - multiplexed 7-segment scanner for HH.MM.SS BCD time
// Snapshots digits once per frame and blinks the field currently being set.
module bcd_display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] h_tens,
    input  logic [3:0] h_units,
    input  logic [3:0] m_tens,
    input  logic [3:0] m_units,
    input  logic [3:0] s_tens,
    input  logic [3:0] s_units,
    input  logic [1:0] blink_sel,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int DIV_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BDIV_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [BDIV_W-1:0] BDIV_LAST = BDIV_W'(BLINK_DIV - 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [2:0]        slot_q, slot_d;
    logic [BDIV_W-1:0] bdiv_q, bdiv_d;
    logic              phase_q, phase_d;
    logic [23:0]       snap_q, snap_d;
    logic [7:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              div_wrap;
    logic [3:0]        digit;
    logic [1:0]        slot_field;
    logic              blank;

    always_comb begin
        div_wrap = (div_q == DIV_LAST);
        div_d    = div_wrap ? '0 : div_q + 1'b1;

        slot_d = slot_q;
        if (slot_q > 3'd5) begin
            slot_d = 3'd0;
        end else if (div_wrap) begin
            slot_d = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
        end

        // Whole-frame capture keeps a carry ripple from tearing across digits.
        snap_d = snap_q;
        if (div_wrap && slot_q == 3'd5) begin
            snap_d = {h_tens, h_units, m_tens, m_units, s_tens, s_units};
        end

        bdiv_d  = (bdiv_q == BDIV_LAST) ? '0 : bdiv_q + 1'b1;
        phase_d = (bdiv_q == BDIV_LAST) ? ~phase_q : phase_q;
    end

    always_comb begin
        digit      = 4'd0;
        slot_field = 2'b00;
        case (slot_q)
            3'd0: begin digit = snap_q[3:0];   slot_field = 2'b11; end
            3'd1: begin digit = snap_q[7:4];   slot_field = 2'b11; end
            3'd2: begin digit = snap_q[11:8];  slot_field = 2'b10; end
            3'd3: begin digit = snap_q[15:12]; slot_field = 2'b10; end
            3'd4: begin digit = snap_q[19:16]; slot_field = 2'b01; end
            3'd5: begin digit = snap_q[23:20]; slot_field = 2'b01; end
            default: begin digit = 4'd0; slot_field = 2'b00; end
        endcase

        blank = phase_q && (blink_sel != 2'b00) && (blink_sel == slot_field);

        case (digit)
            4'd0:    seg_d = 7'h40;
            4'd1:    seg_d = 7'h79;
            4'd2:    seg_d = 7'h24;
            4'd3:    seg_d = 7'h30;
            4'd4:    seg_d = 7'h19;
            4'd5:    seg_d = 7'h12;
            4'd6:    seg_d = 7'h02;
            4'd7:    seg_d = 7'h78;
            4'd8:    seg_d = 7'h00;
            4'd9:    seg_d = 7'h10;
            default: seg_d = 7'h3F;
        endcase

        an_d = 8'hFF;
        dp_d = 1'b1;
        if (slot_q <= 3'd5 && !blank) begin
            an_d[slot_q] = 1'b0;
            dp_d = !(slot_q == 3'd2 || slot_q == 3'd4);
        end
        if (blank || slot_q > 3'd5) begin
            seg_d = 7'h7F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            slot_q  <= 3'd0;
            bdiv_q  <= '0;
            phase_q <= 1'b0;
            snap_q  <= 24'd0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            div_q   <= div_d;
            slot_q  <= slot_d;
            bdiv_q  <= bdiv_d;
            phase_q <= phase_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - directed self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] h_tens, h_units, m_tens, m_units, s_tens, s_units;
    logic [1:0] blink_sel;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_fails  = 0;

    bcd_display_scanner #(.REFRESH_DIV(4), .BLINK_DIV(64)) dut (
        .clk(clk), .rst(rst),
        .h_tens(h_tens), .h_units(h_units), .m_tens(m_tens),
        .m_units(m_units), .s_tens(s_tens), .s_units(s_units),
        .blink_sel(blink_sel), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock, then compare all outputs; seg is skipped while a field is blanked.
    task automatic step(input string tag, input logic [7:0] exp_an, input logic [6:0] exp_seg,
                        input logic exp_dp, input logic chk_seg);
        tick();
        check8({tag, " an"}, an, exp_an);
        if (chk_seg) check8({tag, " seg"}, {1'b0, seg}, {1'b0, exp_seg});
        check8({tag, " dp"}, {7'd0, dp}, {7'd0, exp_dp});
    endtask

    task automatic run_slot(input string tag, input int slot, input logic [6:0] exp_seg);
        logic [7:0] a;
        a = ~(8'h01 << slot);
        for (int i = 0; i < 4; i++) begin
            step(tag, a, exp_seg, !(slot == 2 || slot == 4), 1'b1);
        end
    endtask

    task automatic set_time(input logic [3:0] ht, hu, mt, mu, st, su);
        h_tens = ht; h_units = hu; m_tens = mt; m_units = mu; s_tens = st; s_units = su;
    endtask

    initial begin
        logic [6:0] tbl [6];
        logic [7:0] ea;
        int slot;
        logic blanked;

        rst = 1'b1;
        blink_sel = 2'b00;
        set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
        tick(); tick(); tick();
        check8("reset an", an, 8'hFF);
        check8("reset seg", {1'b0, seg}, 8'h7F);
        check8("reset dp", {7'd0, dp}, 8'h01);

        // Frame 0 shows the all-zero reset snapshot.
        rst = 1'b0;
        for (int s = 0; s < 6; s++) run_slot("frame0", s, 7'h40);

        // Frame 1: 23:59:58; new inputs queued for the next snapshot.
        run_slot("f1 s0", 0, 7'h00);
        run_slot("f1 s1", 1, 7'h12);
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        run_slot("f1 s2", 2, 7'h10);
        run_slot("f1 s3", 3, 7'h12);
        run_slot("f1 s4", 4, 7'h30);
        run_slot("f1 s5", 5, 7'h24);

        // Frame 2: 12:34:56, inputs zeroed mid-frame must stay invisible.
        run_slot("f2 s0", 0, 7'h02);
        run_slot("f2 s1", 1, 7'h12);
        run_slot("f2 s2", 2, 7'h19);
        set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        run_slot("tear s3", 3, 7'h30);
        run_slot("tear s4", 4, 7'h24);
        run_slot("tear s5", 5, 7'h79);

        run_slot("f3 s0", 0, 7'h40);
        run_slot("f3 s1", 1, 7'h40);
        set_time(4'd1, 4'd9, 4'd0, 4'hC, 4'd0, 4'd7);
        for (int s = 2; s < 6; s++) run_slot("f3 zero", s, 7'h40);

        // Frame 4: 19:0C:07 with invalid m_units.
        run_slot("bad s0", 0, 7'h78);
        run_slot("bad s1", 1, 7'h40);
        run_slot("bad s2", 2, 7'h3F);
        run_slot("bad s3", 3, 7'h40);
        run_slot("bad s4", 4, 7'h10);
        run_slot("bad s5", 5, 7'h79);

        // Reset while position 3 is lit.
        run_slot("f5 s0", 0, 7'h78);
        run_slot("f5 s1", 1, 7'h40);
        run_slot("f5 s2", 2, 7'h3F);
        step("f5 s3", 8'hF7, 7'h40, 1'b1, 1'b1);
        step("f5 s3", 8'hF7, 7'h40, 1'b1, 1'b1);
        rst = 1'b1;
        blink_sel = 2'b01;
        step("midreset", 8'hFF, 7'h7F, 1'b1, 1'b1);
        rst = 1'b0;

        // Hours blink: blanked at reset-relative cycles 65..128, then 00 never blanks.
        tbl[0] = 7'h78; tbl[1] = 7'h40; tbl[2] = 7'h3F;
        tbl[3] = 7'h40; tbl[4] = 7'h10; tbl[5] = 7'h79;
        for (int e = 1; e <= 256; e++) begin
            if (e == 193) blink_sel = 2'b00;
            slot = ((e - 1) / 4) % 6;
            blanked = (e >= 65 && e <= 128 && slot >= 4);
            ea = blanked ? 8'hFF : ~(8'h01 << slot);
            step(blanked ? "blink off" : "blink on", ea,
                 (e <= 24) ? 7'h40 : tbl[slot],
                 blanked ? 1'b1 : !(slot == 2 || slot == 4), !blanked);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
